// File: rtl/rapid_pkg.sv
// Shared types for the memory stage: control bundles, stage states, funct3
// encodings and the access validity/alignment rules used at capture and hold.
package rapid_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef struct packed {
        logic       mem;
        logic       iop;
        logic [2:0] fcs_opcode;
        logic [4:0] rd;
    } control_mem_s;

    typedef struct packed {
        logic       we;
        logic [4:0] rd;
    } control_wb_s;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } mem_state_e;

    function automatic control_mem_s control_mem_s_default();
        return '0;
    endfunction

    function automatic control_wb_s control_wb_s_default();
        return '0;
    endfunction

    function automatic logic mem_op_valid(input logic iop, input logic [2:0] funct3);
        if (iop) return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
               (funct3 == LBU) || (funct3 == LHU);
    endfunction

    // Only meaningful for valid opcodes; funct3[1:0] encodes the access size.
    function automatic logic mem_op_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Combinational lane logic for the held memory op: store byte enables and
// replication, load lane extraction with sign/zero extension, validity checks.
module load_store_align
    import rapid_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            mem,
    input  logic            iop,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic            access_ok,
    output logic            misaligned,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic            valid;
    logic            mis;
    logic [XLEN-1:0] byte_word;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;

    assign valid      = mem_op_valid(iop, funct3);
    assign mis        = mem_op_misaligned(funct3, addr_lo);
    assign misaligned = mem && valid && mis;
    assign access_ok  = mem && valid && !mis;

    always_comb begin
        be    = 4'hF;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'hF;
                wdata = store_data;
            end
        endcase
    end

    assign byte_word = rdata >> {addr_lo, 3'b000};
    assign lane_b    = byte_word[7:0];
    assign lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (funct3)
            LB:      load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
            LH:      load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
            LBU:     load_data = {{(XLEN-8){1'b0}}, lane_b};
            LHU:     load_data = {{(XLEN-16){1'b0}}, lane_h};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: holds one instruction, runs its data-memory access,
// forwards its result and registers the writeback. MEMORY_STAGE_TIMEOUT_EN adds a bus timeout.
module memory_stage
    import rapid_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_pipeline_enable,
    input  control_mem_s    i_control_signal,
    input  logic [XLEN-1:0] i_rd_output,
    input  logic [XLEN-1:0] i_memory_data,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_stall,
    output logic [4:0]      o_mem_rd,
    output logic [XLEN-1:0] o_mem_rd_data,
    output logic            o_misaligned,
    output logic            o_bus_error,
    output control_wb_s     o_wb_control,
    output logic [XLEN-1:0] o_wb_data
);

    mem_state_e      state_q, state_d;
    control_mem_s    ctrl_q;
    logic [XLEN-1:0] addr_q, data_q, hold_q;
    logic [XLEN-1:0] load_data, fwd_data;
    logic            access_ok, misaligned;
    logic            capture, ack_now, next_access;
    logic            timeout, bus_err, retire_ok;

    load_store_align #(.XLEN(XLEN)) u_align (
        .mem        (ctrl_q.mem),
        .iop        (ctrl_q.iop),
        .funct3     (ctrl_q.fcs_opcode),
        .addr_lo    (addr_q[1:0]),
        .store_data (data_q),
        .rdata      (i_dmem_rdata),
        .access_ok  (access_ok),
        .misaligned (misaligned),
        .be         (o_dmem_be),
        .wdata      (o_dmem_wdata),
        .load_data  (load_data)
    );

    assign ack_now     = (state_q == ACCESS) && i_dmem_ack;
    assign o_stall     = (state_q == ACCESS) && !i_dmem_ack;
    assign capture     = i_pipeline_enable && !o_stall;
    assign next_access = i_control_signal.mem &&
                         mem_op_valid(i_control_signal.iop, i_control_signal.fcs_opcode) &&
                         !mem_op_misaligned(i_control_signal.fcs_opcode, i_rd_output[1:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HOLD: begin
                if (capture) state_d = next_access ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (ack_now) begin
                    if (i_pipeline_enable) state_d = next_access ? ACCESS : IDLE;
                    else                   state_d = HOLD;
                end else if (timeout) begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result of the held instruction: live bus data on ack, parked data in HOLD.
    always_comb begin
        fwd_data = addr_q;
        if (ack_now)               fwd_data = load_data;
        else if (state_q == HOLD)  fwd_data = hold_q;
    end

    assign retire_ok     = !ctrl_q.mem || (access_ok && !ctrl_q.iop && !bus_err);
    assign o_mem_rd      = retire_ok ? ctrl_q.rd : 5'd0;
    assign o_mem_rd_data = fwd_data;
    assign o_misaligned  = misaligned;
    assign o_bus_error   = bus_err;
    assign o_dmem_req    = (state_q == ACCESS);
    assign o_dmem_we     = ctrl_q.iop;
    assign o_dmem_addr   = {addr_q[XLEN-1:2], 2'b00};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            ctrl_q       <= control_mem_s_default();
            addr_q       <= '0;
            data_q       <= '0;
            hold_q       <= '0;
            o_wb_control <= control_wb_s_default();
            o_wb_data    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                ctrl_q       <= i_control_signal;
                addr_q       <= i_rd_output;
                data_q       <= i_memory_data;
                o_wb_control <= control_wb_s'{we: retire_ok && (ctrl_q.rd != 5'd0), rd: ctrl_q.rd};
                o_wb_data    <= fwd_data;
            end
            if (ack_now && !i_pipeline_enable) hold_q <= load_data;
        end
    end

`ifdef MEMORY_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    assign timeout = (state_q == ACCESS) && !i_dmem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err = bus_err_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (capture || state_q != ACCESS) cnt_q <= '0;
            else                              cnt_q <= cnt_q + CNT_W'(1);
            if (capture)      bus_err_q <= 1'b0;
            else if (timeout) bus_err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: byte-level memory reference model feeds expectation
// queues for writeback and bus requests; a monitor checks them as the DUT presents them.
module tb_memory_stage;
    import rapid_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_pipeline_enable = 1'b0;
    control_mem_s i_control_signal = '0;
    logic [31:0]  i_rd_output = '0;
    logic [31:0]  i_memory_data = '0;
    logic         o_dmem_req, o_dmem_we;
    logic [31:0]  o_dmem_addr, o_dmem_wdata;
    logic [3:0]   o_dmem_be;
    logic         i_dmem_ack;
    logic [31:0]  i_dmem_rdata;
    logic         o_stall;
    logic [4:0]   o_mem_rd;
    logic [31:0]  o_mem_rd_data;
    logic         o_misaligned, o_bus_error;
    control_wb_s  o_wb_control;
    logic [31:0]  o_wb_data;

    memory_stage dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pipeline_enable(i_pipeline_enable),
        .i_control_signal(i_control_signal), .i_rd_output(i_rd_output),
        .i_memory_data(i_memory_data), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall),
        .o_mem_rd(o_mem_rd), .o_mem_rd_data(o_mem_rd_data), .o_misaligned(o_misaligned),
        .o_bus_error(o_bus_error), .o_wb_control(o_wb_control), .o_wb_data(o_wb_data)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    // wb entry: {we, rd, data}; dmem entry: {we, addr, be, wdata, rd, load value}
    logic [37:0]  exp_q[$];
    logic [105:0] dm_q[$];
    logic [7:0]   ref_mem[64];
    logic [31:0]  slave_mem[16];
    int           forced_wait = -1;
    bit           exp_bus_err = 1'b0;
    bit           pending_cap = 1'b0;
    int           req_cycles = 0;
    int           last_stalls = 0;
    logic [31:0]  last_load = '0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        slave_mem[i] = v;
        for (int b = 0; b < 4; b++) ref_mem[4*i+b] = v[8*b +: 8];
    endtask

    task automatic settle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic gap(input int n);
        i_pipeline_enable = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Reference model: compute the instruction's architectural effect, then drive it.
    task automatic issue(input logic mem, input logic iop, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d);
        int          size, off, lane, n;
        bit          valid, mis;
        logic [31:0] val, wd;
        logic [3:0]  be;
        logic        we;
        if (!mem) begin
            we = (rd != 5'd0);
            exp_q.push_back({we, rd, a});
        end else begin
            valid = iop ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
            size  = 1 << f3[1:0];
            mis   = (int'(a[1:0]) % size) != 0;
            off   = int'(a - 32'h100);
            if (!valid || mis) begin
                exp_q.push_back({1'b0, rd, 32'h0});
            end else if (iop) begin
                be = '0;
                for (int l = 0; l < 4; l++) wd[8*l +: 8] = d[8*(l % size) +: 8];
                for (int b = 0; b < size; b++) begin
                    lane = int'(a[1:0]) + b;
                    be[lane] = 1'b1;
                    ref_mem[off+b] = d[8*b +: 8];
                end
                dm_q.push_back({1'b1, a & 32'hFFFF_FFFC, be, wd, 5'd0, 32'h0});
                exp_q.push_back({1'b0, rd, 32'h0});
            end else begin
                val = '0;
                for (int b = 0; b < size; b++) val[8*b +: 8] = ref_mem[off+b];
                if (!f3[2] && size < 4 && val[8*size-1])
                    for (int k = 8*size; k < 32; k++) val[k] = 1'b1;
                we = (rd != 5'd0) && !exp_bus_err;
                dm_q.push_back({1'b0, a & 32'hFFFF_FFFC, 4'h0, 32'h0, rd, val});
                exp_q.push_back({we, rd, val});
                last_load = val;
            end
        end
        i_control_signal  = '{mem: mem, iop: iop, fcs_opcode: f3, rd: rd};
        i_rd_output       = a;
        i_memory_data     = d;
        i_pipeline_enable = 1'b1;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (!o_stall) break;
            n++;
            if (n >= 200) begin
                chk("issue_timeout", 1, 0);
                finish_run();
            end
        end
        @(posedge i_clk);
        #1;
        i_pipeline_enable = 1'b0;
        last_stalls = n;
    endtask

    task automatic nop();
        issue(1'b0, 1'b0, 3'd0, 5'd0, $urandom, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        i_pipeline_enable = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        exp_q.delete();
        dm_q.delete();
        exp_q.push_back('0);
        forced_wait = -1;
    endtask

    // Data-memory slave with per-request random or forced wait states.
    initial begin
        int wcnt;
        bit fresh;
        int idx;
        wcnt = 0;
        fresh = 1'b1;
        i_dmem_ack = 1'b0;
        i_dmem_rdata = '0;
        forever begin
            @(posedge i_clk);
            #1;
            i_dmem_ack = 1'b0;
            i_dmem_rdata = $urandom;
            if (!o_dmem_req) begin
                fresh = 1'b1;
            end else begin
                if (fresh) begin
                    wcnt = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
                    fresh = 1'b0;
                end
                if (wcnt == 0) begin
                    idx = int'(o_dmem_addr[5:2]);
                    i_dmem_ack = 1'b1;
                    i_dmem_rdata = slave_mem[idx];
                    if (o_dmem_we)
                        for (int l = 0; l < 4; l++)
                            if (o_dmem_be[l]) slave_mem[idx][8*l +: 8] = o_dmem_wdata[8*l +: 8];
                    fresh = 1'b1;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Monitor: retirements pop the writeback queue, bus cycles check the request queue.
    initial begin
        logic [37:0]  e;
        logic [105:0] de;
        forever begin
            @(negedge i_clk);
            if (pending_cap) begin
                if (exp_q.size() == 0) chk("wb_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wb_ctrl", {o_wb_control.we, o_wb_control.rd}, e[37:32]);
                    if (e[37]) chk("wb_data", o_wb_data, e[31:0]);
                end
            end
            pending_cap = i_pipeline_enable && !o_stall && !i_reset;
            if (o_dmem_req) begin
                req_cycles++;
                if (dm_q.size() == 0) chk("dmem_unexpected", 1, 0);
                else begin
                    de = dm_q[0];
                    chk("dmem_we", o_dmem_we, de[105]);
                    chk("dmem_addr", o_dmem_addr, de[104:73]);
                    if (de[105]) begin
                        chk("dmem_be", o_dmem_be, de[72:69]);
                        chk("dmem_wdata", o_dmem_wdata, de[68:37]);
                    end
                    chk("stall_access", o_stall, !i_dmem_ack);
                    if (i_dmem_ack) begin
                        if (!de[105]) begin
                            chk("fwd_rd", o_mem_rd, de[36:32]);
                            chk("fwd_data", o_mem_rd_data, de[31:0]);
                        end
                        void'(dm_q.pop_front());
                    end
                end
            end else begin
                chk("stall_idle", o_stall, 0);
            end
        end
    end

    initial begin
        #1000000;
        chk("watchdog", 1, 0);
        finish_run();
    end

    initial begin
        int r0, n;
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        exp_q.push_back('0);
        @(negedge i_clk);
        chk("rst_req", o_dmem_req, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_wb_ctrl", o_wb_control, 0);
        chk("rst_wb_data", o_wb_data, 0);
        chk("rst_bus_error", o_bus_error, 0);
        chk("rst_mem_rd", o_mem_rd, 0);
        settle();

        // SW with two wait states
        forced_wait = 2;
        issue(1'b1, 1'b1, SW, 5'd7, 32'h100, 32'hDEADBEEF);
        r0 = req_cycles;
        nop();
        chk("sw_stall_cycles", last_stalls, 2);
        chk("sw_req_cycles", req_cycles - r0, 3);
        chk("sw_wb_we", o_wb_control.we, 0);

        // SB into the top lane
        forced_wait = 1;
        issue(1'b1, 1'b1, SB, 5'd0, 32'h103, 32'h000000A5);
        nop();

        // LB / LBU with zero-wait ack
        set_word(0, 32'h12F03456);
        forced_wait = 0;
        issue(1'b1, 1'b0, LB, 5'd9, 32'h102, 32'h0);
        nop();
        chk("lb_stall_cycles", last_stalls, 0);
        chk("lb_wb_data", o_wb_data, 32'hFFFFFFF0);
        issue(1'b1, 1'b0, LBU, 5'd10, 32'h102, 32'h0);
        nop();
        chk("lbu_wb_data", o_wb_data, 32'h000000F0);

        // Misaligned LH
        forced_wait = -1;
        r0 = req_cycles;
        issue(1'b1, 1'b0, LH, 5'd5, 32'h101, 32'h0);
        @(negedge i_clk);
        chk("mis_flag", o_misaligned, 1);
        chk("mis_req", o_dmem_req, 0);
        chk("mis_mem_rd", o_mem_rd, 0);
        settle();
        nop();
        chk("mis_no_req", req_cycles - r0, 0);
        chk("mis_wb_we", o_wb_control.we, 0);

        // LW acked while the pipeline is frozen -> HOLD
        forced_wait = 1;
        issue(1'b1, 1'b0, LW, 5'd11, 32'h100, 32'h0);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_dmem_req && n < 20);
        chk("hold_req", o_dmem_req, 0);
        chk("hold_stall", o_stall, 0);
        chk("hold_fwd_rd", o_mem_rd, 11);
        chk("hold_fwd_data", o_mem_rd_data, last_load);
        settle();
        nop();
        chk("hold_wb_data", o_wb_data, last_load);

        // Reset while an access is outstanding
        forced_wait = 10;
        issue(1'b1, 1'b0, LW, 5'd12, 32'h104, 32'h0);
        do_reset();
        @(negedge i_clk);
        chk("rstacc_req", o_dmem_req, 0);
        chk("rstacc_stall", o_stall, 0);
        chk("rstacc_wb_ctrl", o_wb_control, 0);
        chk("rstacc_wb_data", o_wb_data, 0);
        settle();

`ifdef MEMORY_STAGE_TIMEOUT_EN
        forced_wait = 1000;
        exp_bus_err = 1'b1;
        issue(1'b1, 1'b0, LW, 5'd3, 32'h108, 32'h0);
        exp_bus_err = 1'b0;
        r0 = req_cycles;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_dmem_req && n < 200);
        chk("to_req_cycles", req_cycles - r0, 64);
        chk("to_bus_error", o_bus_error, 1);
        chk("to_stall", o_stall, 0);
        chk("to_mem_rd", o_mem_rd, 0);
        dm_q.delete();
        forced_wait = -1;
        settle();
        nop();
        chk("to_wb_we", o_wb_control.we, 0);
        @(negedge i_clk);
        chk("to_bus_error_clear", o_bus_error, 0);
        settle();
`else
        chk("no_bus_error", o_bus_error, 0);
`endif

        // Random instruction mix with random bus latency and frozen cycles
        forced_wait = -1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 9) < 7)
                issue(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      5'($urandom_range(0, 31)), 32'h100 + $urandom_range(0, 63), $urandom);
            else
                issue(1'b0, 1'b0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                      $urandom, $urandom);
        end
        nop();
        nop();
        @(negedge i_clk);
        #1;
        chk("exp_q_left", exp_q.size(), 1);
        chk("dm_q_left", dm_q.size(), 0);
        finish_run();
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's memory control bundle, ALU result/effective address and store data.
- Performs byte/half/word loads and stores over a req/ack data-memory port, and stalls the pipeline while an access is outstanding.
- Drives the MEM→EX forwarding pair (rd, rd data) and a registered writeback bundle to the register-file write stage.

Parameters:
- XLEN, 32, datapath width (must be 32).
- TIMEOUT_CYCLES, 64, ACCESS-state cycle limit; used only when MEMORY_STAGE_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_pipeline_enable  in  1  global advance; the stage captures new inputs only when high.
- i_control_signal  in  control_mem_s  mem, iop (1=store), fcs_opcode (funct3), rd.
- i_rd_output  in  XLEN  ALU result, or effective address when mem=1.
- i_memory_data  in  XLEN  store data (already forwarded).
- o_dmem_req  out  1  access request.
- o_dmem_we  out  1  1=write.
- o_dmem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}.
- o_dmem_wdata  out  XLEN  lane-replicated store data.
- o_dmem_be  out  4  byte enables.
- i_dmem_ack  in  1  access complete; rdata valid the same cycle.
- i_dmem_rdata  in  XLEN  read word.
- o_stall  out  1  stage cannot retire this cycle.
- o_mem_rd  out  5  forwarding destination (0 = none).
- o_mem_rd_data  out  XLEN  forwarding data.
- o_misaligned  out  1  current instruction is a misaligned access.
- o_bus_error  out  1  access timed out (timeout build only; else tied 0).
- o_wb_control  out  control_wb_s  {we, rd}, registered.
- o_wb_data  out  XLEN  registered writeback value.

Behaviour:
- Reset (synchronous; takes priority over i_pipeline_enable):
  - stage registers cleared, control = control_mem_s_default(), state IDLE.
  - o_dmem_req = 0, o_stall = 0, o_wb_control = '0, o_wb_data = 0.
- Capture: on a clock edge with i_pipeline_enable=1 and o_stall=0, stage registers take ctrl/addr/data. At the same edge, o_wb_* take the retiring instruction's result.
- Retiring instruction writeback:
  - we = 1 for non-mem with rd≠0, or a valid aligned load with rd≠0.
  - we = 0 for stores, misaligned accesses, invalid fcs_opcode and bus errors.
- Alignment and validity:
  - Load fcs_opcode 000/001/010/100/101; any other value is a no-op (no request).
  - Store fcs_opcode 000/001/010; any other value is a no-op.
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, is misaligned: o_misaligned=1 while the instruction is held, no request issued.
- States:
  - IDLE:
    - Entered on capture of a non-mem, invalid or misaligned op.
    - o_dmem_req=0, o_stall=0.
  - ACCESS:
    - Entered on capture of a valid aligned mem op.
    - o_dmem_req=1; address, wdata, be and we stable until ack.
    - o_stall = !i_dmem_ack.
    - On ack with i_pipeline_enable=1: retire; the next state is decided by the newly captured op.
    - On ack with i_pipeline_enable=0: latch the formatted load data into the hold buffer, go to HOLD.
    - A zero-wait ack (ack in the first ACCESS cycle) is legal.
  - HOLD:
    - o_dmem_req=0, o_stall=0, result comes from the hold buffer.
    - Leaves on capture, to the state decided by the new op.
- Store formatting:
  - SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{data[15:0]}}.
  - SW: be=4'hF, wdata=data.
- Load formatting: select the byte/half lane from addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Forwarding outputs:
  - o_mem_rd = rd for non-mem ops and valid loads; 0 for stores, misaligned and invalid ops.
  - o_mem_rd_data = formatted i_dmem_rdata during the ack cycle, hold buffer in HOLD, otherwise the ALU result.
  - A load in ACCESS without ack stalls, so the forwarded value is never consumed before it is valid.
- Reset during ACCESS: req drops after the reset edge and the access is abandoned; the slave must tolerate a dropped request.

Optional Feature:
- MEMORY_STAGE_TIMEOUT_EN defined:
  - A cycle counter runs in ACCESS.
  - After TIMEOUT_CYCLES cycles without ack: drop req, assert o_bus_error, suppress writeback, enter HOLD.
  - o_bus_error stays high until the next capture.
- Undefined: no counter; ACCESS waits indefinitely; o_bus_error=0.

Decomposition:
- rapid_pkg:
  - control_wb_s and control_wb_s_default().
  - mem_state_e {IDLE, ACCESS, HOLD}.
  - Funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
- One combinational sub-module, load_store_align: store lane/be generation, load extraction/extension, misalign and validity detect.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, ack after 2 cycles → req held 3 cycles, be=F, o_stall=1 for 2 cycles, wb we=0.
- SB addr=0x103, data=0x000000A5 → be=4'b1000, wdata=0xA5A5A5A5, dmem_addr=0x100.
- LB addr=0x102 with rdata=0x12F03456 → wb_data=0xFFFFFFF0; LBU same → 0x000000F0; zero-wait ack → no stall.
- LH addr=0x101 → o_misaligned=1, no req, wb we=0, o_mem_rd=0.
- LW ack arrives while i_pipeline_enable=0 → HOLD, o_mem_rd_data = hold buffer = rdata, correct wb_data on the later advance.
- Reset mid-ACCESS → req=0 next cycle; o_wb_*=0. Timeout build: no ack for 64 cycles → o_bus_error=1, wb we=0.
